// File: rtl/uart_stream.sv
// ---------------------------------------------------------------------------
// uart_stream
//
// Byte-stream UART bridge: 8 data bits, no parity, 1 stop bit, LSB first,
// line idle high. The transmitter drains a valid/ready byte stream onto
// uart_tx_o. The receiver turns uart_rx_i frames into a valid/ready byte
// stream through a single-entry output buffer.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4)
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_data_i    byte to transmit
//   in_valid_i   transmit byte offered
//   in_ready_o   transmitter idle; byte taken on in_valid_i & in_ready_o
//   out_data_o   received byte, stable while out_valid_o is high
//   out_valid_o  received byte available
//   out_ready_i  consumer takes byte on out_valid_o & out_ready_i
//   uart_tx_o    serial output
//   uart_rx_i    serial input (asynchronous)
//   frame_err_o  one-cycle pulse: stop bit sampled low
//   overrun_o    one-cycle pulse: received byte dropped, buffer full
// ---------------------------------------------------------------------------
module uart_stream #(
    parameter int CLKS_PER_BIT = 417
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] in_data_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       uart_tx_o,
    input  logic       uart_rx_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    // -----------------------------------------------------------------------
    // Transmitter
    // -----------------------------------------------------------------------
    tx_state_e       tx_state_q, tx_state_d;
    logic [TW-1:0]   tx_timer_q, tx_timer_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_q, tx_d;
    logic            in_ready_q, in_ready_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state_q <= TX_IDLE;
            tx_timer_q <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            in_ready_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_timer_q <= tx_timer_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_timer_d = tx_timer_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        in_ready_d = in_ready_q;

        case (tx_state_q)
            TX_IDLE: begin
                // Ready comes up on the first edge out of reset and stays up.
                in_ready_d = 1'b1;
                tx_d       = 1'b1;
                if (in_valid_i && in_ready_q) begin
                    tx_shift_d = in_data_i;
                    tx_d       = 1'b0;
                    in_ready_d = 1'b0;
                    tx_timer_d = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_timer_d = tx_timer_q + TIMER_ONE;
                end
            end
            TX_DATA: begin
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        // Bit on the line is always shift[0]; advance by one.
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_timer_d = tx_timer_q + TIMER_ONE;
                end
            end
            TX_STOP: begin
                if (tx_timer_q == BIT_LAST) begin
                    tx_timer_d = '0;
                    in_ready_d = 1'b1;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_timer_d = tx_timer_q + TIMER_ONE;
                end
            end
            default: begin
                tx_d       = 1'b1;
                in_ready_d = 1'b0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    assign uart_tx_o  = tx_q;
    assign in_ready_o = in_ready_q;

    // -----------------------------------------------------------------------
    // Receiver: 2-flop synchronizer, reset to the idle (high) level so a
    // reset never looks like a start bit.
    // -----------------------------------------------------------------------
    logic rx_sync1_q, rx_sync2_q;
    logic rx_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
        end else begin
            rx_sync1_q <= uart_rx_i;
            rx_sync2_q <= rx_sync1_q;
        end
    end

    assign rx_s = rx_sync2_q;

    rx_state_e       rx_state_q, rx_state_d;
    logic [TW-1:0]   rx_timer_q, rx_timer_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_done_q, rx_done_d;   // good stop bit seen last cycle
    logic            rx_bad_q, rx_bad_d;     // bad stop bit seen last cycle

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state_q <= RX_IDLE;
            rx_timer_q <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_done_q  <= 1'b0;
            rx_bad_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_timer_q <= rx_timer_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_done_q  <= rx_done_d;
            rx_bad_q   <= rx_bad_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_timer_d = rx_timer_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done_d  = 1'b0;
        rx_bad_d   = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_timer_d = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Re-check at mid start bit to reject short glitches.
                if (rx_timer_q == HALF_LAST) begin
                    rx_timer_d = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_timer_d = rx_timer_q + TIMER_ONE;
                end
            end
            RX_DATA: begin
                if (rx_timer_q == BIT_LAST) begin
                    rx_timer_d = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_timer_d = rx_timer_q + TIMER_ONE;
                end
            end
            RX_STOP: begin
                if (rx_timer_q == BIT_LAST) begin
                    rx_timer_d = '0;
                    if (rx_s) begin
                        rx_done_d  = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_bad_d   = 1'b1;
                        rx_state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_timer_d = rx_timer_q + TIMER_ONE;
                end
            end
            RX_WAIT_HIGH: begin
                // A held-low line (break) must not re-trigger a frame.
                if (rx_s) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Single-entry output buffer. rx_shift_q is not touched again until the
    // next frame's first data sample, so it is safe to load from one cycle
    // after the stop sample.
    // -----------------------------------------------------------------------
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = rx_bad_q;

        if (rx_done_q) begin
            // A consume in the same cycle frees the slot for the new byte.
            if (!out_valid_q || out_ready_i) begin
                out_data_d  = rx_shift_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_stream.sv
// ---------------------------------------------------------------------------
// tb_uart_stream: directed self-checking bench for uart_stream at
// CLKS_PER_BIT = 8. Inputs change on the falling edge, outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_stream;

    localparam int CPB = 8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] in_data_i = 8'h00;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [7:0] out_data_o;
    logic       out_valid_o;
    logic       out_ready_i = 1'b0;
    logic       uart_tx_o;
    logic       uart_rx_i = 1'b1;
    logic       frame_err_o;
    logic       overrun_o;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int ferr_cnt = 0;

    uart_stream #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .uart_tx_o   (uart_tx_o),
        .uart_rx_i   (uart_rx_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (overrun_o === 1'b1) ovr_cnt = ovr_cnt + 1;
        if (frame_err_o === 1'b1) ferr_cnt = ferr_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready_o !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: in_ready_o=%b after %0d cycles, need 1", in_ready_o, n);
        end
    endtask

    // Serial frame on uart_rx_i, one bit per CPB cycles; line left at stop level.
    task automatic rx_send(input logic [7:0] b, input logic stop_bit, input logic rdy_at_load);
        uart_rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            tick(CPB);
        end
        uart_rx_i = stop_bit;
        tick(CPB - 1);
        // The buffer loads on the edge just before the final falling edge.
        out_ready_i = rdy_at_load;
        tick(1);
        out_ready_i = 1'b0;
    endtask

    task automatic consume();
        out_ready_i = 1'b1;
        tick(1);
        out_ready_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL consume_clear: out_valid_o=%b, need 0", out_valid_o);
        end
    endtask

    task automatic test_reset();
        logic [9:0] pat;
        tick(3);
        checks++;
        if ({uart_tx_o, in_ready_o, out_valid_o, out_data_o, frame_err_o, overrun_o} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: tx=%b rdy=%b vld=%b data=%h ferr=%b ovr=%b, need 1 0 0 00 0 0",
                     uart_tx_o, in_ready_o, out_valid_o, out_data_o, frame_err_o, overrun_o);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: in_ready_o=%b, need 0", in_ready_o);
        end
        tick(1);
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: in_ready_o=%b, need 1", in_ready_o);
        end
        // Mid-frame reset: start an A5 frame, stop during data bit 1 (low).
        pat = {1'b1, 8'hA5, 1'b0};
        in_data_i = 8'hA5;
        in_valid_i = 1'b1;
        tick(1);
        in_valid_i = 1'b0;
        tick(20);
        checks++;
        if (uart_tx_o !== pat[2]) begin
            errors++;
            $display("FAIL midtx_pre: uart_tx_o=%b, need %b", uart_tx_o, pat[2]);
        end
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if ({uart_tx_o, in_ready_o, out_valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL midtx_async_reset: tx=%b rdy=%b vld=%b, need 1 0 0", uart_tx_o, in_ready_o, out_valid_o);
        end
        tick(3);
        rst_i = 1'b0;
        tick(1);
        checks++;
        if ({uart_tx_o, in_ready_o} !== 2'b11) begin
            errors++;
            $display("FAIL midtx_release: tx=%b rdy=%b, need 1 1", uart_tx_o, in_ready_o);
        end
    endtask

    task automatic test_tx_a5();
        logic [9:0] pat;
        pat = {1'b1, 8'hA5, 1'b0};
        wait_ready();
        in_data_i = 8'hA5;
        in_valid_i = 1'b1;
        for (int k = 0; k < 10 * CPB; k++) begin
            tick(1);
            if (k == 0) in_valid_i = 1'b0;
            checks++;
            if (uart_tx_o !== pat[k / CPB]) begin
                errors++;
                $display("FAIL tx_a5_bit: cycle %0d uart_tx_o=%b, need %b", k, uart_tx_o, pat[k / CPB]);
            end
            checks++;
            if (in_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL tx_a5_busy: cycle %0d in_ready_o=%b, need 0", k, in_ready_o);
            end
        end
        tick(1);
        checks++;
        if ({uart_tx_o, in_ready_o} !== 2'b11) begin
            errors++;
            $display("FAIL tx_a5_end: tx=%b rdy=%b, need 1 1", uart_tx_o, in_ready_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] p0, p1;
        logic       exp_tx, exp_rdy;
        p0 = {1'b1, 8'h00, 1'b0};
        p1 = {1'b1, 8'hFF, 1'b0};
        wait_ready();
        in_data_i = 8'h00;
        in_valid_i = 1'b1;
        for (int k = 0; k <= 20 * CPB; k++) begin
            tick(1);
            if (k == 0) in_data_i = 8'hFF;
            if (k < 10 * CPB)       exp_tx = p0[k / CPB];
            else if (k == 10 * CPB) exp_tx = 1'b1;
            else                    exp_tx = p1[(k - 10 * CPB - 1) / CPB];
            exp_rdy = (k == 10 * CPB);
            checks++;
            if ({uart_tx_o, in_ready_o} !== {exp_tx, exp_rdy}) begin
                errors++;
                $display("FAIL b2b_line: cycle %0d tx=%b rdy=%b, need %b %b", k, uart_tx_o, in_ready_o, exp_tx, exp_rdy);
            end
            if (k == 10 * CPB + 1) in_valid_i = 1'b0;
        end
        tick(1);
        checks++;
        if ({uart_tx_o, in_ready_o} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_end: tx=%b rdy=%b, need 1 1", uart_tx_o, in_ready_o);
        end
    endtask

    task automatic test_rx_hold();
        int bad;
        rx_send(8'h3C, 1'b1, 1'b0);
        tick(1);
        checks++;
        if ({out_valid_o, out_data_o} !== {1'b1, 8'h3C}) begin
            errors++;
            $display("FAIL rx_3c: vld=%b data=%h, need 1 3c", out_valid_o, out_data_o);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if ({out_valid_o, out_data_o} !== {1'b1, 8'h3C}) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rx_3c_stable: %0d unstable cycles, need 0", bad);
        end
        consume();
        checks++;
        if (out_data_o !== 8'h3C) begin
            errors++;
            $display("FAIL rx_3c_hold_data: data=%h, need 3c", out_data_o);
        end
    endtask

    task automatic test_overrun();
        int o0;
        o0 = ovr_cnt;
        rx_send(8'h11, 1'b1, 1'b0);
        rx_send(8'h22, 1'b1, 1'b0);
        tick(2);
        checks++;
        if ({out_valid_o, out_data_o} !== {1'b1, 8'h11}) begin
            errors++;
            $display("FAIL ovr_keep_old: vld=%b data=%h, need 1 11", out_valid_o, out_data_o);
        end
        checks++;
        if (ovr_cnt - o0 !== 1) begin
            errors++;
            $display("FAIL ovr_pulse: %0d pulses, need 1", ovr_cnt - o0);
        end
        consume();
        // Same pair, but the consumer takes 11 on the very edge 22 arrives.
        o0 = ovr_cnt;
        rx_send(8'h11, 1'b1, 1'b0);
        rx_send(8'h22, 1'b1, 1'b1);
        tick(2);
        checks++;
        if ({out_valid_o, out_data_o} !== {1'b1, 8'h22}) begin
            errors++;
            $display("FAIL ovr_simul: vld=%b data=%h, need 1 22", out_valid_o, out_data_o);
        end
        checks++;
        if (ovr_cnt - o0 !== 0) begin
            errors++;
            $display("FAIL ovr_simul_pulse: %0d pulses, need 0", ovr_cnt - o0);
        end
        consume();
    endtask

    task automatic test_frame_err();
        int f0;
        f0 = ferr_cnt;
        rx_send(8'h55, 1'b0, 1'b0);
        tick(120);
        checks++;
        if (ferr_cnt - f0 !== 1) begin
            errors++;
            $display("FAIL ferr_count_low: %0d pulses, need 1", ferr_cnt - f0);
        end
        checks++;
        if ({out_valid_o, out_data_o} !== {1'b0, 8'h22}) begin
            errors++;
            $display("FAIL ferr_no_data: vld=%b data=%h, need 0 22", out_valid_o, out_data_o);
        end
        uart_rx_i = 1'b1;
        tick(20);
        checks++;
        if (ferr_cnt - f0 !== 1) begin
            errors++;
            $display("FAIL ferr_count_high: %0d pulses, need 1", ferr_cnt - f0);
        end
        rx_send(8'h5A, 1'b1, 1'b0);
        tick(1);
        checks++;
        if ({out_valid_o, out_data_o} !== {1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL ferr_recover: vld=%b data=%h, need 1 5a", out_valid_o, out_data_o);
        end
        consume();
    endtask

    task automatic test_glitch();
        int f0, o0;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        uart_rx_i = 1'b0;
        tick(2);
        uart_rx_i = 1'b1;
        tick(100);
        checks++;
        if ({out_valid_o, out_data_o} !== {1'b0, 8'h5A}) begin
            errors++;
            $display("FAIL glitch_no_rx: vld=%b data=%h, need 0 5a", out_valid_o, out_data_o);
        end
        checks++;
        if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin
            errors++;
            $display("FAIL glitch_no_err: %0d error pulses, need 0", (ferr_cnt - f0) + (ovr_cnt - o0));
        end
        rx_send(8'hC3, 1'b1, 1'b0);
        tick(1);
        checks++;
        if ({out_valid_o, out_data_o} !== {1'b1, 8'hC3}) begin
            errors++;
            $display("FAIL glitch_then_rx: vld=%b data=%h, need 1 c3", out_valid_o, out_data_o);
        end
    endtask

    // C3 is still buffered here; reset mid-way through another frame.
    task automatic test_reset_rx();
        int f0, o0;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        uart_rx_i = 1'b0;
        tick(12);
        rst_i = 1'b1;
        #1;
        checks++;
        if ({out_valid_o, out_data_o} !== {1'b0, 8'h00}) begin
            errors++;
            $display("FAIL rxrst_clear: vld=%b data=%h, need 0 00", out_valid_o, out_data_o);
        end
        uart_rx_i = 1'b1;
        tick(3);
        rst_i = 1'b0;
        tick(100);
        checks++;
        if ({out_valid_o, out_data_o} !== {1'b0, 8'h00}) begin
            errors++;
            $display("FAIL rxrst_partial_lost: vld=%b data=%h, need 0 00", out_valid_o, out_data_o);
        end
        checks++;
        if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin
            errors++;
            $display("FAIL rxrst_no_err: %0d error pulses, need 0", (ferr_cnt - f0) + (ovr_cnt - o0));
        end
    endtask

    initial begin
        test_reset();
        test_tx_a5();
        test_back_to_back();
        test_rx_hold();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_rx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
